// File: rtl/phase_step_meter_pkg.sv
// Shared constants, FSM encoding and width helpers for the phase step meter.
package phase_step_meter_pkg;

    localparam int PHASE_W    = 8;
    localparam int PHASE_FULL = 256;
    localparam int EDGE_W     = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_GATE = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Gate counter spans exactly PHASE_FULL << gate_shift clocks.
    function automatic int gate_cnt_w(input int gate_shift);
        return PHASE_W + gate_shift;
    endfunction

    // A window holds at most half as many rises as clocks, so one bit more than
    // the gate counter can never reach its limit; capped at the 15-bit result.
    function automatic int edge_cnt_w(input int gate_shift);
        if (PHASE_W + gate_shift + 1 > EDGE_W) begin
            return EDGE_W;
        end
        return PHASE_W + gate_shift + 1;
    endfunction

endpackage

// File: rtl/phase_step_meter_edge_sync.sv
// Input synchronizer followed by a rising-edge detector. While load_i is high
// the previous-sample flop is refreshed but no rise is reported, so arming the
// measurement never counts a stale edge.
module edge_sync_detect
    import phase_step_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    input  logic load_i,
    output logic rise_o
);

    logic cur;
    logic prev_q;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign cur = sig_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Shift the raw input through the synchronizer chain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= sig_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign cur = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Previous sample tracks the synced input every cycle (also covers the ARM load).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= cur;
        end
    end

    assign rise_o = cur & ~prev_q & ~load_i;

endmodule

// File: rtl/phase_step_meter.sv
// Frequency-to-step meter: counts rising edges of sig_in over a gate window of
// 256 << GATE_SHIFT clocks and reports the equivalent 8-bit accumulator step.
module phase_step_meter
    import phase_step_meter_pkg::*;
#(
    parameter int GATE_SHIFT  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [7:0]        step_out,
    output logic [EDGE_W-1:0] edge_count,
    output logic              overflow
);

    localparam int GCW = gate_cnt_w(GATE_SHIFT);
    localparam int ECW = edge_cnt_w(GATE_SHIFT);
    localparam logic [GCW-1:0] GATE_LAST = GCW'((PHASE_FULL << GATE_SHIFT) - 1);

    logic [1:0]        state_q, state_d;
    logic [GCW-1:0]    gate_q, gate_d;
    logic [ECW-1:0]    edges_q, edges_d;
    logic [ECW-1:0]    edges_inc, edges_shr;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        step_q, step_d;
    logic [EDGE_W-1:0] ecnt_q, ecnt_d;
    logic              rise;
    logic              arm;

    assign arm = (state_q == ST_ARM);

    edge_sync_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_detect (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (sig_in),
        .load_i (arm),
        .rise_o (rise)
    );

    // Saturating edge count including this cycle's rise, and its step scaling.
    always_comb begin
        edges_inc = edges_q;
        if (rise && (edges_q != '1)) begin
            edges_inc = edges_q + ECW'(1);
        end
        edges_shr = edges_inc >> GATE_SHIFT;
    end

    // Measurement sequencer; results are latched on the final gate cycle so
    // they are already valid while done is high.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edges_d = edges_q;
        done_d  = 1'b0;
        step_d  = step_q;
        ecnt_d  = ecnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                gate_d  = '0;
                edges_d = '0;
                state_d = ST_GATE;
            end
            ST_GATE: begin
                gate_d  = gate_q + GCW'(1);
                edges_d = edges_inc;
                if (gate_q == GATE_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    ecnt_d  = EDGE_W'(edges_inc);
                    ovf_d   = |edges_shr[ECW-1:PHASE_W];
                    step_d  = (|edges_shr[ECW-1:PHASE_W]) ? 8'hFF : edges_shr[PHASE_W-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any measurement in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gate_q  <= '0;
            edges_q <= '0;
            done_q  <= 1'b0;
            step_q  <= '0;
            ecnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edges_q <= edges_d;
            done_q  <= done_d;
            step_q  <= step_d;
            ecnt_q  <= ecnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign step_out   = step_q;
    assign edge_count = ecnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_phase_step_meter.sv
// Bench for phase_step_meter: two instances (GATE_SHIFT=2/SYNC=2 and
// GATE_SHIFT=0/SYNC=0) share one stimulus source. Expected counts come from a
// recorded history of sig_in: the meter sees the input delayed by its
// synchronizer depth and counts rises among the 256<<GATE_SHIFT+1 samples that
// follow the cycle in which start was taken.
module tb_phase_step_meter;

    localparam int GS_A = 2;
    localparam int SS_A = 2;
    localparam int GS_B = 0;
    localparam int SS_B = 0;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        sig_in  = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [7:0]  step_a, step_b;
    logic [14:0] ec_a, ec_b;

    phase_step_meter #(.GATE_SHIFT(GS_A), .SYNC_STAGES(SS_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start_a),
        .busy(busy_a), .done(done_a), .step_out(step_a),
        .edge_count(ec_a), .overflow(ovf_a)
    );

    phase_step_meter #(.GATE_SHIFT(GS_B), .SYNC_STAGES(SS_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start_b),
        .busy(busy_b), .done(done_b), .step_out(step_b),
        .edge_count(ec_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    int         ecount   = 0;
    bit         hist [65536];
    int         src_mode = 0;
    int         src_step = 0;
    int         src_lvl  = 0;
    int         p3       = 0;
    logic [7:0] acc      = 8'd0;
    int         n_chk    = 0;
    int         n_pass   = 0;

    typedef struct {
        int dut;
        int mode;
        int step;
        int phase;
        int lvl;
        int exp_ec;
        int exp_so;
    } vec_t;

    vec_t tbl [8];

    always @(posedge clk) ecount = ecount + 1;

    // Stimulus source, updated on the falling edge; hist[k] is the value of
    // sig_in present at rising edge number k.
    always @(negedge clk) begin
        case (src_mode)
            0: sig_in = src_lvl[0];
            1: begin
                acc    = acc + src_step[7:0];
                sig_in = acc[7];
            end
            2: begin
                p3     = (p3 + 1) % 3;
                sig_in = (p3 == 0);
            end
            3: sig_in = ~sig_in;
            default: sig_in = 1'($urandom_range(0, 1));
        endcase
        if (ecount + 1 < 65536) hist[ecount + 1] = sig_in;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Rises among the samples the meter looks at for a start taken at edge t.
    function automatic int model_edges(input int t, input int gs, input int ss);
        int cnt = 0;
        for (int i = t + 1 - ss; i <= t + (256 << gs) - ss; i++) begin
            if (hist[i + 1] && !hist[i]) cnt++;
        end
        return (cnt > 32767) ? 32767 : cnt;
    endfunction

    // Select a source pattern and let it settle through the synchronizers.
    task automatic set_src(input int mode, input int step, input int phase, input int lvl);
        src_mode = mode;
        src_step = step;
        src_lvl  = lvl;
        acc      = 8'(phase);
        p3       = 0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic measure(input string tag, input int d, input int poke_at,
                           output int ec, output int so, output int ov);
        int gs, ss, n, t, lat, exp_ec, e;
        gs = (d == 0) ? GS_A : GS_B;
        ss = (d == 0) ? SS_A : SS_B;
        n  = 256 << gs;
        @(negedge clk);
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        t = ecount + 1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        lat = 1;
        check({tag, "_busy"}, int'((d == 0) ? busy_a : busy_b), 1);
        while (!((d == 0) ? done_a : done_b) && lat < n + 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke_at > 0 && lat == poke_at) begin
                if (d == 0) start_a = 1'b1; else start_b = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
        end
        check({tag, "_latency"}, lat, n + 2);
        ec = int'((d == 0) ? ec_a : ec_b);
        so = int'((d == 0) ? step_a : step_b);
        ov = int'((d == 0) ? ovf_a : ovf_b);
        exp_ec = model_edges(t, gs, ss);
        e = exp_ec >> gs;
        check({tag, "_edge_count"}, ec, exp_ec);
        check({tag, "_step_out"}, so, (e > 255) ? 255 : e);
        check({tag, "_overflow"}, ov, (e > 255) ? 1 : 0);
        $display("%s dut=%0d latency=%0d edge_count=%0d step_out=%0d overflow=%0d model=%0d",
                 tag, d, lat, ec, so, ov, exp_ec);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, int'((d == 0) ? done_a : done_b), 0);
        check({tag, "_busy_fall"}, int'((d == 0) ? busy_a : busy_b), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ec, so, ov, nd, stp, ph, d;

        tbl[0] = '{0, 1, 5,   0,   0, 20,  5};
        tbl[1] = '{0, 1, 1,   200, 0, 4,   1};
        tbl[2] = '{0, 1, 128, 0,   0, 512, 128};
        tbl[3] = '{0, 0, 0,   0,   0, 0,   0};
        tbl[4] = '{0, 0, 0,   0,   1, 0,   0};
        tbl[5] = '{1, 3, 0,   0,   0, 128, 128};
        tbl[6] = '{1, 1, 3,   17,  0, 3,   3};
        tbl[7] = '{0, 1, 100, 37,  0, 400, 100};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_step", int'(step_a), 0);
        check("rst_edges", int'(ec_a), 0);
        check("rst_ovf", int'(ovf_a), 0);
        check("rst_busy_b", int'(busy_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven measurements.
        for (int i = 0; i < 8; i++) begin
            set_src(tbl[i].mode, tbl[i].step, tbl[i].phase, tbl[i].lvl);
            measure($sformatf("vec%0d", i), tbl[i].dut, 0, ec, so, ov);
            check($sformatf("vec%0d_table_edges", i), ec, tbl[i].exp_ec);
            check($sformatf("vec%0d_table_step", i), so, tbl[i].exp_so);
        end

        // Square wave with a rise every 3 clocks, 256-clock window.
        set_src(2, 0, 0, 0);
        measure("period3", 1, 0, ec, so, ov);
        check("period3_range", int'(ec == 85 || ec == 86), 1);
        check("period3_step_eq", so, ec);

        // Random accumulator steps in the exact range, random start phase.
        for (int r = 0; r < 4; r++) begin
            d   = r % 2;
            stp = $urandom_range(1, 128);
            ph  = $urandom_range(0, 255);
            set_src(1, stp, ph, 0);
            measure($sformatf("racc%0d", r), d, 0, ec, so, ov);
            check($sformatf("racc%0d_exact", r), ec, stp << ((d == 0) ? GS_A : GS_B));
        end

        // Random bit streams, checked against the sample-history model.
        for (int r = 0; r < 4; r++) begin
            set_src(4, 0, 0, 0);
            measure($sformatf("rbits%0d", r), r % 2, 0, ec, so, ov);
        end

        // Start pulsed mid-gate is ignored: same latency, one done only.
        set_src(3, 0, 0, 0);
        measure("poke", 1, 100, ec, so, ov);
        check("poke_edges", ec, 128);
        nd = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (done_b) nd++;
        end
        check("poke_extra_done", nd, 0);

        // Reset dropped mid-gate aborts; a later start runs a full window.
        set_src(1, 9, 0, 0);
        measure("pre_rst", 0, 0, ec, so, ov);
        check("pre_rst_edges", ec, 36);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy_a), 0);
        check("abort_done", int'(done_a), 0);
        check("abort_step", int'(step_a), 0);
        check("abort_edges", int'(ec_a), 0);
        check("abort_ovf", int'(ovf_a), 0);
        check("abort_edges_b", int'(ec_b), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (1100) begin
            @(posedge clk);
            #1;
            if (done_a) nd++;
        end
        check("abort_no_done", nd, 0);
        measure("post_rst", 0, 0, ec, so, ov);
        check("post_rst_edges", ec, 36);
        check("post_rst_step", so, 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/phase_step_meter.md
Name: phase_step_meter

Overview:
- Measures a periodic 1-bit input (typically the MSB of a phase accumulator, or an external square wave) and recovers the 8-bit accumulator step that would reproduce its frequency.
- It is the read-back end of the phase-counter path and is used for self-test and loopback of the function generator.
- Counts rising edges over a gate window of 256·2^GATE_SHIFT clocks, then reports step = edges >> GATE_SHIFT.
- Start/busy/done handshake.

Parameters:
- GATE_SHIFT, 2, gate window = 256 << GATE_SHIFT clocks; legal 0..6.
- SYNC_STAGES, 2, input synchronizer depth; 0 = bypass (on-chip synchronous source).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sig_in  input  1  signal under measurement.
- start  input  1  one-cycle request to begin a measurement; accepted only in IDLE.
- busy  output  1  high while a measurement is in progress.
- done  output  1  one-cycle pulse when results update.
- step_out  output  8  measured step, held until next done.
- edge_count  output  15  raw rising-edge count of the last window.
- overflow  output  1  set with done when edges >> GATE_SHIFT > 255; step_out saturates to 255.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, step_out=0, edge_count=0, overflow=0; synchronizer and edge-detect registers cleared to 0. Release is synchronous to the next clk edge.
- Input path: SYNC_STAGES flops, then a previous-sample flop; rise = cur & ~prev.
- FSM states:
  - IDLE: start=1 → ARM.
  - ARM: 1 cycle; loads prev with the current synced sample so no false edge is counted; clears the gate counter and edge counter → GATE.
  - GATE: gate counter increments each cycle; edge counter increments on every rise. On the cycle where the gate counter reaches 256<<GATE_SHIFT − 1, that cycle's rise is included → DONE.
  - DONE: 1 cycle; registers edge_count, computes step_out and overflow, pulses done → IDLE.
- busy = 1 in ARM, GATE and DONE; busy falls in the cycle after the done pulse.
- Latency: start sampled at edge t → done high during cycle t + 2 + (256<<GATE_SHIFT).
- start while busy: ignored; no queuing, no restart.
- Arithmetic:
  - Edge counter is 15 bits and saturates at 0x7FFF; it never wraps.
  - step_out = min(edge_count >> GATE_SHIFT, 255), truncating.
  - overflow = (edge_count >> GATE_SHIFT) > 255.
- Accuracy: for a source accumulator with step S ≤ 128 clocked on clk, the count is exactly S·2^GATE_SHIFT regardless of start phase. S > 128 aliases (MSB undersampled); the result is defined as whatever is counted, with no error flag.
- Constant sig_in (0 or 1) → step_out = 0, overflow = 0.
- Reset mid-measurement: aborts immediately to reset values; no done pulse.
- Outputs change only in DONE or on reset; step_out, edge_count and overflow hold through subsequent IDLE/GATE.

Decomposition:
- Shared package:
  - PHASE_W = 8.
  - PHASE_FULL = 256.
  - FSM state encoding {IDLE, ARM, GATE, DONE} as 2-bit constants.
  - Edge-counter width function of GATE_SHIFT.
- One sub-module: edge_sync_detect (SYNC_STAGES synchronizer + rise detect, with a load input used by ARM).

Test Plan:
- Loopback a phase counter with step=5, GATE_SHIFT=2, pulse start → done after 1026 cycles; edge_count=20, step_out=5, overflow=0.
- Step=1 with init phase 200, then step=128 with init phase 0 → step_out=1, then 128. Verifies exactness at both extremes and phase independence.
- sig_in held 0, then held 1 → step_out=0, edge_count=0, no spurious edge from ARM.
- External square wave with period 3 clocks (rises every 3), GATE_SHIFT=0 → edge_count=85 or 86, step_out equal to it, overflow=0.
- GATE_SHIFT=0, SYNC_STAGES=0, sig_in toggling every cycle → edge_count=128, step_out=128. Then assert start during GATE → ignored, exactly one done.
- Drop rst_n midway through GATE → busy=0 and all outputs 0 within the same cycle, no done. A new start after release runs a full window.
